// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between execute, the ALU result stage and writeback.
// master drives the upstream entry and the writeback ready; slave is the stage.
interface alu_result_stage_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      valid_in;
  logic                      ready_out;
  logic [DATA_WIDTH-1:0]     result_in;
  logic                      zeroFlag_in;
  logic [1:0]                branchType_in;
  logic [DATA_WIDTH-1:0]     pc_in;
  logic [DATA_WIDTH-1:0]     offset_in;
  logic                      regWrite_in;
  logic [REG_ADDR_WIDTH-1:0] rdAddr_in;
  logic                      flush_in;
  logic                      ready_in;
  logic                      valid_out;
  logic                      wbEnable_out;
  logic [REG_ADDR_WIDTH-1:0] wbAddr_out;
  logic [DATA_WIDTH-1:0]     wbData_out;
  logic                      branchTaken_out;
  logic [DATA_WIDTH-1:0]     branchTarget_out;

  modport master (
    output valid_in, result_in, zeroFlag_in, branchType_in, pc_in, offset_in,
           regWrite_in, rdAddr_in, flush_in, ready_in,
    input  ready_out, valid_out, wbEnable_out, wbAddr_out, wbData_out,
           branchTaken_out, branchTarget_out
  );

  modport slave (
    input  valid_in, result_in, zeroFlag_in, branchType_in, pc_in, offset_in,
           regWrite_in, rdAddr_in, flush_in, ready_in,
    output ready_out, valid_out, wbEnable_out, wbAddr_out, wbData_out,
           branchTaken_out, branchTarget_out
  );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer after the ALU: resolves branches at accept, drives the
// register-file write port and a one-cycle fetch redirect from the head entry.
module alu_result_stage #(
  parameter int DATA_WIDTH_POW = 6,
  parameter int DATA_WIDTH     = 1 << DATA_WIDTH_POW,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic               clk_in,
  input logic               reset_in,
  alu_result_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     wbData;
    logic [DATA_WIDTH-1:0]     target;
    logic                      taken;
    logic                      regWrite;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } entry_t;

  state_t stateReg;
  logic   readyReg;
  entry_t mainReg;
  entry_t skidReg;
  entry_t newEntry;
  logic   accept;
  logic   retire;
  logic   squash;

  // Taken, target and writeback value are resolved once at accept time.
  always_comb begin
    newEntry          = '0;
    newEntry.target   = bus.pc_in + bus.offset_in;
    newEntry.regWrite = bus.regWrite_in;
    newEntry.rd       = bus.rdAddr_in;
    newEntry.wbData   = bus.result_in;
    unique case (bus.branchType_in)
      2'd1:    newEntry.taken = bus.zeroFlag_in;
      2'd2:    newEntry.taken = ~bus.zeroFlag_in;
      2'd3: begin
        newEntry.taken  = 1'b1;
        newEntry.wbData = bus.pc_in + DATA_WIDTH'(4);
      end
      default: newEntry.taken = 1'b0;
    endcase
  end

  assign accept = bus.valid_in & readyReg;
  assign retire = (stateReg != EMPTY) & bus.ready_in;
  assign squash = retire & mainReg.taken;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      stateReg <= EMPTY;
      readyReg <= 1'b1;
      mainReg  <= '0;
      skidReg  <= '0;
    end else if (bus.flush_in || squash) begin
      // Anything younger than a taken branch or a flush is wrong-path.
      stateReg <= EMPTY;
      readyReg <= 1'b1;
    end else begin
      unique case (stateReg)
        EMPTY: begin
          if (accept) begin
            mainReg  <= newEntry;
            stateReg <= ONE;
          end
        end
        ONE: begin
          if (accept && retire) begin
            mainReg <= newEntry;
          end else if (accept) begin
            skidReg  <= newEntry;
            stateReg <= TWO;
            readyReg <= 1'b0;
          end else if (retire) begin
            stateReg <= EMPTY;
          end
        end
        TWO: begin
          if (retire) begin
            mainReg  <= skidReg;
            stateReg <= ONE;
            readyReg <= 1'b1;
          end
        end
        default: begin
          stateReg <= EMPTY;
          readyReg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_out        = readyReg;
  assign bus.valid_out        = (stateReg != EMPTY);
  assign bus.wbEnable_out     = retire & mainReg.regWrite & (mainReg.rd != '0);
  assign bus.wbAddr_out       = mainReg.rd;
  assign bus.wbData_out       = mainReg.wbData;
  assign bus.branchTaken_out  = squash;
  assign bus.branchTarget_out = mainReg.target;
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered consumer of the ALU result and zero flag. Sits between execute and writeback/fetch-redirect.
- Accepts one ALU result per cycle through a valid/ready handshake and buffers up to two entries in a skid buffer, so upstream ready is a register output.
- Resolves BEQ/BNE/JAL-style branches from the zero flag and drives the register-file write port plus a one-cycle fetch redirect.

Parameters:
- DATA_WIDTH_POW, 6, log2 of datapath width.
- DATA_WIDTH, 1 << DATA_WIDTH_POW, datapath width in bits.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk_in  input  1  clock, all state on rising edge
- reset_in  input  1  asynchronous, active-high reset
- valid_in  input  1  upstream entry valid
- ready_out  output  1  stage can accept an entry; registered
- result_in  input  DATA_WIDTH  ALU result
- zeroFlag_in  input  1  ALU zero flag
- branchType_in  input  2  0=NONE, 1=BEQ, 2=BNE, 3=JUMP
- pc_in  input  DATA_WIDTH  PC of the instruction
- offset_in  input  DATA_WIDTH  sign-extended branch offset
- regWrite_in  input  1  instruction writes rd
- rdAddr_in  input  REG_ADDR_WIDTH  destination register
- flush_in  input  1  discard all buffered entries
- ready_in  input  1  writeback can accept
- valid_out  output  1  head entry valid
- wbEnable_out  output  1  valid_out & ready_in & head.regWrite & (head.rd != 0)
- wbAddr_out  output  REG_ADDR_WIDTH  head rd
- wbData_out  output  DATA_WIDTH  head result, or head pc+4 for JUMP
- branchTaken_out  output  1  one-cycle pulse when a taken branch retires
- branchTarget_out  output  DATA_WIDTH  head pc + offset, mod 2^DATA_WIDTH

Behaviour:
- Handshakes:
  - Accept occurs when valid_in & ready_out at the clock edge.
  - Retire occurs when valid_out & ready_in at the clock edge.
- Storage: two entries, MAIN (head) and SKID.
  - FSM states: EMPTY, ONE (MAIN full), TWO (MAIN and SKID full).
  - ready_out = (state != TWO), registered from next-state.
  - valid_out = (state != EMPTY).
- Taken decision, computed at accept and stored per entry:
  - BEQ: zeroFlag_in.
  - BNE: ~zeroFlag_in.
  - JUMP: 1.
  - NONE: 0.
- Branch target:
  - pc_in + offset_in, computed at accept and stored.
  - Overflow wraps; no carry out.
- State transitions:
  - EMPTY + accept -> ONE, entry into MAIN.
  - ONE + accept + retire -> ONE, MAIN replaced by the new entry.
  - ONE + accept only -> TWO, entry into SKID.
  - ONE + retire only -> EMPTY.
  - TWO + retire -> ONE, SKID moves to MAIN. Accept is impossible because ready_out=0.
  - TWO + no retire -> TWO, contents held stable.
- Output timing:
  - Outputs are combinational from MAIN only.
  - Latency from accept to valid_out is 1 cycle.
  - Output data is stable while valid_out & ~ready_in.
- branchTaken_out:
  - Asserted only in the retire cycle of a taken entry, combinationally (head.taken & retire).
  - Never asserted while ~ready_in.
- Taken-branch squash:
  - When a taken entry retires, the other buffered entry is invalidated in the same edge (state -> EMPTY).
  - An entry accepted in that same cycle is also dropped.
  - Younger entries are wrong-path.
- flush_in:
  - Synchronous; state -> EMPTY next edge and any same-cycle accept is dropped.
  - A retire in the flush cycle still completes.
  - ready_out = 1 the cycle after flush_in.
- Reset (asynchronous, immediate):
  - state = EMPTY.
  - valid_out, wbEnable_out and branchTaken_out = 0.
  - ready_out = 1.
  - Data registers cleared to 0.
  - Reset mid-operation discards all entries.
- Register x0: writes to rd=0 never assert wbEnable_out; the entry still retires.
- JUMP writeback value: wbData_out = pc+4, wrapping.

Test Plan:
- Streaming: reset, then valid_in=1 and ready_in=1 for 4 cycles with result=1,2,3,4, NONE, rd=5 -> wbData_out 1,2,3,4 on consecutive cycles starting 1 cycle after the first accept; ready_out stays 1.
- Backpressure: ready_in=0, accept results 0xA then 0xB -> state TWO, ready_out=0 on the cycle after the second accept, wbData_out holds 0xA. Raise ready_in -> 0xA then 0xB retire, and ready_out=1 after the first retire.
- Branch resolve: BEQ with zeroFlag=1, pc=0x100, offset=0x40 -> branchTaken_out pulse with target 0x140. BNE with zeroFlag=1 -> no pulse. BEQ with pc=0xFFFF_FFFF_FFFF_FFF0 and offset=0x20 -> target 0x10.
- Squash: MAIN = taken BEQ, SKID = add to rd=3, ready_in=1 -> branch retires, SKID is discarded, valid_out=0 next cycle, and rd=3 is never written.
- Flush/x0/JUMP:
  - flush_in while in TWO -> EMPTY next cycle.
  - regWrite=1 with rd=0 -> wbEnable_out stays 0.
  - JUMP with pc=0x200 -> wbData_out=0x204 and a taken pulse.
- Reset mid-operation: assert reset_in asynchronously between edges while in TWO -> valid_out=0 and ready_out=1 immediately. After deassertion, the first accepted entry is the first output.
